// File: rtl/tx_frame_sequencer.sv
// Frame sequencer: fetches one byte per frame from memory, handshakes CTS/RTS,
// launches the serializer and counts completed frames for a GO-started job.
module tx_frame_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned CTS_TIMEOUT = 50000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              GO,
    input  logic [7:0]        MODE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [15:0]       PKT_COUNT,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    input  logic              CTS,
    output logic              TX_START,
    output logic [7:0]        TX_DATA,
    output logic [7:0]        TX_MODE,
    input  logic              TX_DONE,
    output logic              RTS,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       SENT,
    output logic              TIMEOUT_ERR
);

    localparam int unsigned CW = $clog2(CTS_TIMEOUT + 1);
    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CTS_LAST = CW'(CTS_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_WAIT_CTS,
        S_LAUNCH,
        S_WAIT_TX,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       remaining_q;
    logic [CW-1:0]     cts_cnt_q;
    logic [GW-1:0]     gap_cnt_q;
    logic              accept_go;
    logic              frame_done;
    logic              timeout_hit;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept_go   = 1'b0;
        frame_done  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (GO) begin
                    accept_go = 1'b1;
                    state_nxt = (PKT_COUNT == 16'd0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH:    state_nxt = S_WAIT_MEM;
            S_WAIT_MEM: state_nxt = S_WAIT_CTS;
            S_WAIT_CTS: begin
                if (CTS) begin
                    state_nxt = S_LAUNCH;
                end else if (cts_cnt_q == CTS_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_FINISH;
                end
            end
            S_LAUNCH: state_nxt = S_WAIT_TX;
            S_WAIT_TX: begin
                if (TX_DONE) begin
                    frame_done = 1'b1;
                    if (remaining_q == 16'd1)  state_nxt = S_FINISH;
                    else if (GAP_CYCLES == 0)  state_nxt = S_FETCH;
                    else                       state_nxt = S_GAP;
                end
            end
            S_GAP:    if (gap_cnt_q == GAP_LAST) state_nxt = S_FETCH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MEM_RD      <= 1'b0;
            MEM_ADDR    <= '0;
            TX_START    <= 1'b0;
            TX_DATA     <= '0;
            TX_MODE     <= '0;
            RTS         <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            SENT        <= '0;
            TIMEOUT_ERR <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            cts_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            MEM_RD   <= (state_nxt == S_FETCH);
            TX_START <= (state_nxt == S_LAUNCH);
            BUSY     <= (state_nxt != S_IDLE);
            DONE     <= (state_nxt == S_FINISH);

            if (state_nxt == S_WAIT_CTS)
                RTS <= 1'b1;
            else if (state_nxt == S_FINISH || state_nxt == S_IDLE)
                RTS <= 1'b0;

            // First fetch of a job uses BASE_ADDR directly; addr_q is only loaded on this edge.
            if (state_nxt == S_FETCH)
                MEM_ADDR <= (state == S_IDLE) ? BASE_ADDR : addr_q;

            cts_cnt_q <= (state == S_WAIT_CTS && !CTS) ? cts_cnt_q + 1'b1 : '0;
            gap_cnt_q <= (state == S_GAP) ? gap_cnt_q + 1'b1 : '0;

            if (accept_go) begin
                TX_MODE     <= MODE;
                addr_q      <= BASE_ADDR;
                remaining_q <= PKT_COUNT;
                SENT        <= '0;
                TIMEOUT_ERR <= 1'b0;
            end

            if (state == S_WAIT_MEM) begin
                TX_DATA <= MEM_DATA;
                addr_q  <= addr_q + 1'b1;
            end

            if (frame_done) begin
                if (SENT != 16'hFFFF) SENT <= SENT + 16'd1;
                remaining_q <= remaining_q - 16'd1;
            end

            if (timeout_hit) TIMEOUT_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: sync-RAM and serializer responders plus a
// job-level timing model derived from the recorded CTS history.
module tb_tx_frame_sequencer;

    localparam int unsigned AW   = 8;
    localparam int unsigned GAP  = 5;
    localparam int unsigned TMO  = 120;
    localparam int unsigned HIST = 16384;

    logic          Clock = 1'b0;
    logic          Reset, GO, MEM_RD, CTS, TX_START, TX_DONE, RTS, BUSY, DONE, TIMEOUT_ERR;
    logic [7:0]    MODE, MEM_DATA, TX_DATA, TX_MODE;
    logic [AW-1:0] BASE_ADDR, MEM_ADDR;
    logic [15:0]   PKT_COUNT, SENT;

    always #5 Clock = ~Clock;

    tx_frame_sequencer #(.ADDR_W(AW), .GAP_CYCLES(GAP), .CTS_TIMEOUT(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .GO(GO), .MODE(MODE), .BASE_ADDR(BASE_ADDR),
        .PKT_COUNT(PKT_COUNT), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .CTS(CTS), .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_MODE(TX_MODE),
        .TX_DONE(TX_DONE), .RTS(RTS), .BUSY(BUSY), .DONE(DONE), .SENT(SENT),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned cyc = 0;
    logic [7:0]  mem [0:255];
    logic        cts_at [0:HIST-1];
    logic        auto_tx = 1'b1, drop_cts = 1'b0, cts_rand = 1'b0;
    int unsigned tx_lat = 20, tx_due = 0, cts_rise_at = 0, go_pulse_at = 0;
    int unsigned done_cnt, done_se;
    logic        rts_at_done, rts_at_rise, busy_after_go;

    // Observed events; *_se is the clock edge at which the DUT output is sampled.
    logic [7:0]  rd_addr_q[$], st_data_q[$], txdone_data_q[$];
    int unsigned rd_se_q[$], st_se_q[$], txdone_se_q[$];

    // Expected events from the model.
    logic [7:0]  e_rd_addr[$], e_st_data[$];
    int unsigned e_rd_se[$], e_st_se[$];
    int unsigned e_done_se;

    task automatic step();
        logic       rd_pre;
        logic [7:0] addr_pre;
        if (cts_rand) CTS = ($urandom_range(0, 3) != 0);
        rd_pre   = MEM_RD;
        addr_pre = MEM_ADDR;
        if (cyc + 1 < HIST) cts_at[cyc + 1] = CTS;
        if (TX_DONE) begin
            txdone_se_q.push_back(cyc + 1);
            txdone_data_q.push_back(TX_DATA);
        end
        @(posedge Clock);
        cyc++;
        #1;
        if (rd_pre) MEM_DATA = mem[addr_pre];
        GO = (go_pulse_at != 0 && cyc == go_pulse_at);
        if (GO) PKT_COUNT = 16'd0;
        if (cts_rise_at != 0 && cyc == cts_rise_at) begin
            rts_at_rise = RTS;
            CTS = 1'b1;
        end
        if (MEM_RD) begin
            rd_addr_q.push_back(MEM_ADDR);
            rd_se_q.push_back(cyc + 1);
        end
        if (TX_START) begin
            st_data_q.push_back(TX_DATA);
            st_se_q.push_back(cyc + 1);
            tx_due = cyc + 1 + tx_lat;
            if (drop_cts) CTS = 1'b0;
        end
        if (DONE) begin
            done_cnt++;
            done_se     = cyc + 1;
            rts_at_done = RTS;
        end
        if (auto_tx) begin
            TX_DONE = (tx_due == cyc + 1);
            if (TX_DONE && drop_cts) CTS = 1'b1;
        end
    endtask

    task automatic run_job(input logic [7:0] mode, input logic [7:0] base, input logic [15:0] count,
                           input int unsigned budget, output int unsigned go_se);
        rd_addr_q.delete(); rd_se_q.delete(); st_data_q.delete(); st_se_q.delete();
        txdone_se_q.delete(); txdone_data_q.delete();
        done_cnt = 0; done_se = 0; rts_at_done = 1'bx;
        MODE = mode; BASE_ADDR = base; PKT_COUNT = count; GO = 1'b1;
        go_se = cyc + 1;
        step();
        busy_after_go = BUSY;
        MODE = 8'($urandom); BASE_ADDR = 8'($urandom); PKT_COUNT = 16'($urandom);
        for (int unsigned k = 0; k < budget; k++) begin
            if (done_cnt != 0) break;
            step();
        end
        step();
        step();
    endtask

    // Job-level model: one read per frame at successive addresses, launch one edge after
    // the first CTS-high sample from two edges past the read, next read GAP+1 after TX_DONE.
    task automatic build_expect(input int unsigned go_se, input logic [7:0] base,
                                input int unsigned count, input int unsigned lat);
        int unsigned next_rd, e, s, t_last;
        logic [7:0]  a;
        e_rd_addr.delete(); e_st_data.delete(); e_rd_se.delete(); e_st_se.delete();
        next_rd = go_se + 1;
        t_last  = 0;
        for (int unsigned i = 0; i < count; i++) begin
            a = base + 8'(i);
            e_rd_addr.push_back(a);
            e_st_data.push_back(mem[a]);
            e_rd_se.push_back(next_rd);
            e = next_rd + 2;
            while (e <= cyc && e < HIST && cts_at[e] !== 1'b1) e++;
            s = e + 1;
            e_st_se.push_back(s);
            t_last  = s + lat;
            next_rd = t_last + GAP + 1;
        end
        e_done_se = (count == 0) ? go_se + 1 : t_last + 1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({MEM_RD, MEM_ADDR, TX_START, TX_DATA, TX_MODE, RTS, BUSY, DONE, SENT, TIMEOUT_ERR} !== '0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {MEM_RD, MEM_ADDR, TX_START, TX_DATA, TX_MODE, RTS, BUSY, DONE, SENT, TIMEOUT_ERR});
        else n_pass++;
        Reset = 1'b0;
        step();
        step();
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL idle_busy: got %b, expected 0", BUSY);
        else n_pass++;
    endtask

    task automatic test_basic();
        int unsigned go_se;
        logic [7:0]  exp_d [3];
        exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
        CTS = 1'b1; tx_lat = 20;
        run_job(8'h3C, 8'h10, 16'd3, 500, go_se);
        build_expect(go_se, 8'h10, 3, 20);
        n_checks++;
        if (busy_after_go !== 1'b1) $display("FAIL basic_busy: got %b, expected 1", busy_after_go);
        else n_pass++;
        n_checks++;
        if (st_se_q.size() != 3 || rd_se_q.size() != 3)
            $display("FAIL basic_counts: got %0d starts %0d reads, expected 3 3", st_se_q.size(), rd_se_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < st_se_q.size() && i < rd_se_q.size(); i++) begin
            n_checks++;
            if (st_data_q[i] !== exp_d[i]) $display("FAIL basic_data%0d: got %h, expected %h", i, st_data_q[i], exp_d[i]);
            else n_pass++;
            n_checks++;
            if (rd_addr_q[i] !== 8'h10 + 8'(i)) $display("FAIL basic_addr%0d: got %h, expected %h", i, rd_addr_q[i], 8'h10 + 8'(i));
            else n_pass++;
            n_checks++;
            if (st_se_q[i] !== e_st_se[i] || rd_se_q[i] !== e_rd_se[i])
                $display("FAIL basic_timing%0d: got rd %0d st %0d, expected rd %0d st %0d",
                         i, rd_se_q[i], st_se_q[i], e_rd_se[i], e_st_se[i]);
            else n_pass++;
        end
        if (st_se_q.size() > 0) begin
            n_checks++;
            if (st_se_q[0] !== go_se + 4) $display("FAIL basic_latency: got %0d, expected %0d", st_se_q[0], go_se + 4);
            else n_pass++;
        end
        for (int i = 0; i < 2 && i + 1 < rd_se_q.size() && i < txdone_se_q.size(); i++) begin
            n_checks++;
            if (rd_se_q[i + 1] - txdone_se_q[i] !== GAP + 1)
                $display("FAIL basic_gap%0d: got %0d, expected %0d", i, rd_se_q[i + 1] - txdone_se_q[i], GAP + 1);
            else n_pass++;
        end
        for (int i = 0; i < 3 && i < txdone_data_q.size(); i++) begin
            n_checks++;
            if (txdone_data_q[i] !== exp_d[i]) $display("FAIL basic_hold%0d: got %h, expected %h", i, txdone_data_q[i], exp_d[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1 || done_se !== e_done_se)
            $display("FAIL basic_done: got %0d pulses at %0d, expected 1 at %0d", done_cnt, done_se, e_done_se);
        else n_pass++;
        n_checks++;
        if (SENT !== 16'd3 || TX_MODE !== 8'h3C) $display("FAIL basic_sent_mode: got %0d %h, expected 3 3c", SENT, TX_MODE);
        else n_pass++;
        n_checks++;
        if (rts_at_done !== 1'b0 || RTS !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL basic_rts_busy: got rts@finish %b rts %b busy %b, expected 0 0 0", rts_at_done, RTS, BUSY);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        int unsigned go_se;
        run_job(8'h11, 8'h50, 16'd0, 20, go_se);
        n_checks++;
        if (rd_se_q.size() != 0 || st_se_q.size() != 0)
            $display("FAIL zero_activity: got %0d reads %0d starts, expected 0 0", rd_se_q.size(), st_se_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_se !== go_se + 1)
            $display("FAIL zero_done: got %0d pulses at %0d, expected 1 at %0d", done_cnt, done_se, go_se + 1);
        else n_pass++;
        n_checks++;
        if (SENT !== 16'd0) $display("FAIL zero_sent: got %0d, expected 0", SENT);
        else n_pass++;
    endtask

    task automatic test_flow_control();
        int unsigned go_se, rise;
        mem[8'h40] = 8'h77;
        CTS = 1'b0;
        rise = cyc + 100;
        cts_rise_at = rise;
        rts_at_rise = 1'bx;
        run_job(8'h22, 8'h40, 16'd1, 400, go_se);
        cts_rise_at = 0;
        n_checks++;
        if (st_se_q.size() != 1 || st_se_q[0] !== rise + 2)
            $display("FAIL flow_start: got %0d starts first at %0d, expected 1 at %0d",
                     st_se_q.size(), (st_se_q.size() > 0) ? st_se_q[0] : 0, rise + 2);
        else n_pass++;
        n_checks++;
        if (rts_at_rise !== 1'b1) $display("FAIL flow_rts: got %b, expected 1", rts_at_rise);
        else n_pass++;
        n_checks++;
        if (SENT !== 16'd1 || TIMEOUT_ERR !== 1'b0)
            $display("FAIL flow_sent: got %0d err %b, expected 1 err 0", SENT, TIMEOUT_ERR);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int unsigned go_se;
        CTS = 1'b0;
        run_job(8'h33, 8'h60, 16'd2, TMO + 60, go_se);
        n_checks++;
        if (done_cnt !== 1 || done_se !== go_se + 3 + TMO)
            $display("FAIL timeout_done: got %0d pulses at %0d, expected 1 at %0d", done_cnt, done_se, go_se + 3 + TMO);
        else n_pass++;
        n_checks++;
        if (TIMEOUT_ERR !== 1'b1 || SENT !== 16'd0)
            $display("FAIL timeout_flag: got err %b sent %0d, expected 1 0", TIMEOUT_ERR, SENT);
        else n_pass++;
        n_checks++;
        if (st_se_q.size() != 0 || rd_se_q.size() != 1)
            $display("FAIL timeout_activity: got %0d starts %0d reads, expected 0 1", st_se_q.size(), rd_se_q.size());
        else n_pass++;
        CTS = 1'b1;
        step();
    endtask

    task automatic test_wrap_cts_drop();
        int unsigned go_se;
        logic [7:0]  exp_a [3];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        for (int i = 0; i < 3; i++) mem[exp_a[i]] = 8'($urandom);
        drop_cts = 1'b1; tx_lat = 15;
        run_job(8'h44, 8'hFE, 16'd3, 500, go_se);
        drop_cts = 1'b0;
        build_expect(go_se, 8'hFE, 3, 15);
        n_checks++;
        if (rd_addr_q.size() != 3 || st_data_q.size() != 3)
            $display("FAIL wrap_counts: got %0d reads %0d starts, expected 3 3", rd_addr_q.size(), st_data_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && i < rd_addr_q.size() && i < st_data_q.size(); i++) begin
            n_checks++;
            if (rd_addr_q[i] !== exp_a[i] || st_data_q[i] !== e_st_data[i])
                $display("FAIL wrap_frame%0d: got addr %h data %h, expected %h %h",
                         i, rd_addr_q[i], st_data_q[i], exp_a[i], e_st_data[i]);
            else n_pass++;
        end
        n_checks++;
        if (SENT !== 16'd3 || done_cnt !== 1 || TIMEOUT_ERR !== 1'b0)
            $display("FAIL wrap_result: got sent %0d done %0d err %b, expected 3 1 0", SENT, done_cnt, TIMEOUT_ERR);
        else n_pass++;
    endtask

    task automatic test_go_while_busy();
        int unsigned go_se;
        mem[8'h20] = 8'h5A; mem[8'h21] = 8'hA5;
        CTS = 1'b1; tx_lat = 20;
        go_pulse_at = cyc + 30;
        run_job(8'h66, 8'h20, 16'd2, 500, go_se);
        go_pulse_at = 0;
        build_expect(go_se, 8'h20, 2, 20);
        n_checks++;
        if (TX_MODE !== 8'h66 || SENT !== 16'd2 || done_cnt !== 1)
            $display("FAIL busy_go_result: got mode %h sent %0d done %0d, expected 66 2 1", TX_MODE, SENT, done_cnt);
        else n_pass++;
        n_checks++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 8'h20 || rd_addr_q[1] !== 8'h21)
            $display("FAIL busy_go_addr: got %0d reads, expected 20 21", rd_addr_q.size());
        else n_pass++;
        n_checks++;
        if (done_se !== e_done_se) $display("FAIL busy_go_done_time: got %0d, expected %0d", done_se, e_done_se);
        else n_pass++;
    endtask

    task automatic test_stray_tx_done();
        auto_tx = 1'b0;
        done_cnt = 0;
        TX_DONE = 1'b1;
        step();
        TX_DONE = 1'b0;
        step();
        step();
        auto_tx = 1'b1;
        n_checks++;
        if (SENT !== 16'd2 || BUSY !== 1'b0 || done_cnt !== 0)
            $display("FAIL stray_tx_done: got sent %0d busy %b done %0d, expected 2 0 0", SENT, BUSY, done_cnt);
        else n_pass++;
    endtask

    task automatic test_random_jobs();
        int unsigned go_se, cnt, lat;
        logic [7:0]  base;
        cts_rand = 1'b1;
        for (int j = 0; j < 6; j++) begin
            base = 8'($urandom);
            cnt  = $urandom_range(1, 4);
            lat  = $urandom_range(1, 30);
            tx_lat = lat;
            for (int unsigned i = 0; i < cnt; i++) mem[base + 8'(i)] = 8'($urandom);
            run_job(8'($urandom), base, 16'(cnt), 1000, go_se);
            build_expect(go_se, base, cnt, lat);
            n_checks++;
            if (rd_se_q.size() != cnt || st_se_q.size() != cnt)
                $display("FAIL rand%0d_counts: got %0d reads %0d starts, expected %0d", j, rd_se_q.size(), st_se_q.size(), cnt);
            else n_pass++;
            for (int i = 0; i < cnt && i < rd_se_q.size() && i < st_se_q.size(); i++) begin
                n_checks++;
                if (rd_addr_q[i] !== e_rd_addr[i] || rd_se_q[i] !== e_rd_se[i] ||
                    st_data_q[i] !== e_st_data[i] || st_se_q[i] !== e_st_se[i])
                    $display("FAIL rand%0d_frame%0d: got a %h@%0d d %h@%0d, expected a %h@%0d d %h@%0d", j, i,
                             rd_addr_q[i], rd_se_q[i], st_data_q[i], st_se_q[i],
                             e_rd_addr[i], e_rd_se[i], e_st_data[i], e_st_se[i]);
                else n_pass++;
            end
            n_checks++;
            if (done_cnt !== 1 || done_se !== e_done_se || SENT !== 16'(cnt))
                $display("FAIL rand%0d_end: got done %0d@%0d sent %0d, expected 1@%0d sent %0d",
                         j, done_cnt, done_se, SENT, e_done_se, cnt);
            else n_pass++;
        end
        cts_rand = 1'b0;
        CTS = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_job();
        mem[8'h80] = 8'hC7;
        auto_tx = 1'b0;
        st_se_q.delete();
        done_cnt = 0;
        MODE = 8'h9D; BASE_ADDR = 8'h80; PKT_COUNT = 16'd2; GO = 1'b1;
        step();
        for (int k = 0; k < 50; k++) begin
            if (st_se_q.size() != 0) break;
            step();
        end
        step();
        step();
        n_checks++;
        if (BUSY !== 1'b1 || RTS !== 1'b1 || TX_DATA !== 8'hC7)
            $display("FAIL midjob_active: got busy %b rts %b data %h, expected 1 1 c7", BUSY, RTS, TX_DATA);
        else n_pass++;
        #2;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({MEM_RD, MEM_ADDR, TX_START, TX_DATA, TX_MODE, RTS, BUSY, DONE, SENT, TIMEOUT_ERR} !== '0)
            $display("FAIL midjob_reset: got %h, expected 0",
                     {MEM_RD, MEM_ADDR, TX_START, TX_DATA, TX_MODE, RTS, BUSY, DONE, SENT, TIMEOUT_ERR});
        else n_pass++;
        step();
        Reset = 1'b0;
        for (int k = 0; k < 10; k++) step();
        n_checks++;
        if (done_cnt !== 0 || BUSY !== 1'b0 || SENT !== 16'd0)
            $display("FAIL midjob_after: got done %0d busy %b sent %0d, expected 0 0 0", done_cnt, BUSY, SENT);
        else n_pass++;
    endtask

    initial begin
        Reset = 1'b1; GO = 1'b0; MODE = '0; BASE_ADDR = '0; PKT_COUNT = '0;
        MEM_DATA = '0; CTS = 1'b1; TX_DONE = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_zero_count();
        test_flow_control();
        test_timeout();
        test_wrap_cts_drop();
        test_go_while_busy();
        test_stray_tx_done();
        test_random_jobs();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
